// File: rtl/fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ctrl_if
// Description : Bundle of FIFO read-side, downstream output and burst status
//               signals for the FIFO read controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              rd_empty;
  logic [DATA_W-1:0] rd_data;
  logic              rd_en;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [9:0]        rd_count;
  logic [DATA_W-1:0] checksum;

  // Controller side
  modport master (
    input  start, rd_empty, rd_data, out_ready,
    output rd_en, out_valid, out_data, busy, done, rd_count, checksum
  );

  // Environment side (FIFO, downstream consumer, sequencer)
  modport slave (
    output start, rd_empty, rd_data, out_ready,
    input  rd_en, out_valid, out_data, busy, done, rd_count, checksum
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ctrl
// Description : Pops BURST_LEN words from a FIFO one at a time, presents each
//               word downstream with a valid/ready handshake, inserts
//               IDLE_CYC idle cycles between words, and reports a word count
//               and running XOR checksum of the burst.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 333,
  parameter int IDLE_CYC  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_rd_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  // Gap counter only needs to hold IDLE_CYC-1
  localparam int              GAP_W      = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD  = (IDLE_CYC > 0) ? GAP_W'(IDLE_CYC - 1) : '0;
  localparam logic [9:0]       BURST_LAST = 10'(BURST_LEN);
  localparam logic [9:0]       CNT_MAX    = 10'h3FF;

  logic [2:0]        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [9:0]        rd_count_q, rd_count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [9:0]        rd_count_inc;
  logic              rd_en, busy, done;

  // Word count after a handshake, saturating at the counter maximum
  assign rd_count_inc = (rd_count_q == CNT_MAX) ? rd_count_q : rd_count_q + 10'd1;

  // State and datapath registers; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rd_count_q  <= '0;
      checksum_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rd_count_q  <= rd_count_d;
      checksum_q  <= checksum_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_count_d  = rd_count_q;
    checksum_d  = checksum_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_READ;
          rd_count_d = '0;
          checksum_d = '0;
        end
      end
      S_READ: begin
        if (!bus.rd_empty) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // FIFO data is valid the cycle after the pop
        out_data_d  = bus.rd_data;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          rd_count_d  = rd_count_inc;
          checksum_d  = checksum_q ^ out_data_q;
          if (rd_count_inc == BURST_LAST) begin
            state_d = S_FINISH;
          end else if (IDLE_CYC == 0) begin
            state_d = S_READ;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_READ;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decoded outputs; the pop is suppressed while reset is asserted
  always_comb begin
    rd_en = rst_n && (state_q == S_READ) && !bus.rd_empty;
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_FINISH);
  end

  assign bus.rd_en     = rd_en;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.rd_count  = rd_count_q;
  assign bus.checksum  = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_ctrl
// Description : Directed self-checking bench for fifo_rd_ctrl. Instance A runs
//               4-word bursts with one idle cycle, instance B runs the default
//               333-word burst with no idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_rd_ctrl_if #(.DATA_W(8)) ifa ();
  fifo_rd_ctrl_if #(.DATA_W(8)) ifb ();

  fifo_rd_ctrl #(.DATA_W(8), .BURST_LEN(4), .IDLE_CYC(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.master)
  );

  fifo_rd_ctrl #(.DATA_W(8), .BURST_LEN(333), .IDLE_CYC(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.master)
  );

  // FIFO model and pop monitor for instance A
  logic [7:0] a_mem [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [1:0] a_idx;
  logic       a_clr;
  int         a_pulses;
  int         a_dones;
  int         a_pcyc [8];

  always @(posedge clk) begin
    if (a_clr) begin
      a_idx    <= 2'd0;
      a_pulses <= 0;
      a_dones  <= 0;
    end else begin
      if (ifa.rd_en) begin
        ifa.rd_data <= a_mem[a_idx];
        a_idx       <= a_idx + 2'd1;
        if (a_pulses < 8) a_pcyc[a_pulses] <= cyc;
        a_pulses    <= a_pulses + 1;
      end
      if (ifa.done) a_dones <= a_dones + 1;
    end
  end

  // FIFO model and pop monitor for instance B: word n (from 1) is n mod 256
  logic b_clr;
  int   b_idx;
  int   b_pulses;
  int   b_first;
  int   b_last;
  int   b_start_cyc;
  int   b_done_cyc;

  always @(posedge clk) begin
    if (ifb.start && !ifb.busy) b_start_cyc <= cyc;
    if (b_clr) begin
      b_idx    <= 0;
      b_pulses <= 0;
    end else begin
      if (ifb.rd_en) begin
        ifb.rd_data <= 8'(b_idx + 1);
        b_idx       <= b_idx + 1;
        if (b_pulses == 0) b_first <= cyc;
        b_last      <= cyc;
        b_pulses    <= b_pulses + 1;
      end
      if (ifb.done) b_done_cyc <= cyc;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_done(input string tag, input int budget);
    for (int i = 0; i < budget && !ifa.done; i++) step();
    chk_eq(tag, 32'(ifa.done), 32'd1);
  endtask

  int  rd_en_seen;
  int  busy_low;
  int  unstable;

  initial begin
    rst_n         = 1'b0;
    a_clr         = 1'b1;
    b_clr         = 1'b1;
    ifa.start     = 1'b0;
    ifa.rd_empty  = 1'b0;
    ifa.out_ready = 1'b1;
    ifb.start     = 1'b0;
    ifb.rd_empty  = 1'b0;
    ifb.out_ready = 1'b1;
    step();
    step();

    // Reset state, with the FIFO reporting non-empty
    chk_eq("rst_rd_en",     32'(ifa.rd_en),     32'd0);
    chk_eq("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk_eq("rst_out_data",  32'(ifa.out_data),  32'd0);
    chk_eq("rst_busy",      32'(ifa.busy),      32'd0);
    chk_eq("rst_done",      32'(ifa.done),      32'd0);
    chk_eq("rst_rd_count",  32'(ifa.rd_count),  32'd0);
    chk_eq("rst_checksum",  32'(ifa.checksum),  32'd0);
    rst_n = 1'b1;
    a_clr = 1'b0;
    b_clr = 1'b0;
    step();

    // Basic 4-word burst, FIFO never empty, consumer always ready
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    wait_a_done("t2_done_seen", 40);
    step();
    chk_eq("t2_pulses",   32'(a_pulses), 32'd4);
    chk_eq("t2_period01", 32'(a_pcyc[1] - a_pcyc[0]), 32'd4);
    chk_eq("t2_period12", 32'(a_pcyc[2] - a_pcyc[1]), 32'd4);
    chk_eq("t2_period23", 32'(a_pcyc[3] - a_pcyc[2]), 32'd4);
    chk_eq("t2_rd_count", 32'(ifa.rd_count), 32'd4);
    chk_eq("t2_checksum", 32'(ifa.checksum), 32'h44);
    chk_eq("t2_dones",    32'(a_dones), 32'd1);
    chk_eq("t2_done_low", 32'(ifa.done), 32'd0);
    chk_eq("t2_busy_low", 32'(ifa.busy), 32'd0);

    // Empty FIFO stall, START ignored in READ and HOLD, consumer backpressure
    a_clr         = 1'b1;
    ifa.start     = 1'b1;
    ifa.rd_empty  = 1'b1;
    ifa.out_ready = 1'b0;
    step();
    a_clr      = 1'b0;
    ifa.start  = 1'b0;
    rd_en_seen = 0;
    busy_low   = 0;
    for (int i = 0; i < 10; i++) begin
      if (ifa.rd_en) rd_en_seen++;
      if (!ifa.busy) busy_low++;
      ifa.start = (i == 5);
      step();
    end
    ifa.start = 1'b0;
    chk_eq("t3_stall_rd_en", 32'(rd_en_seen), 32'd0);
    chk_eq("t3_stall_busy",  32'(busy_low),   32'd0);
    ifa.rd_empty = 1'b0;
    #1;
    chk_eq("t3_rd_en_same_cycle", 32'(ifa.rd_en), 32'd1);
    step();
    chk_eq("t3_capture_valid", 32'(ifa.out_valid), 32'd0);
    chk_eq("t3_capture_rd_en", 32'(ifa.rd_en),     32'd0);
    step();
    chk_eq("t3_hold_valid", 32'(ifa.out_valid), 32'd1);
    chk_eq("t3_hold_data",  32'(ifa.out_data),  32'h11);
    rd_en_seen = 0;
    unstable   = 0;
    for (int i = 0; i < 5; i++) begin
      if (ifa.rd_en) rd_en_seen++;
      if (!ifa.out_valid || ifa.out_data != 8'h11 || ifa.rd_count != 10'd0) unstable++;
      ifa.start = (i == 2);
      step();
    end
    ifa.start = 1'b0;
    chk_eq("t3_bp_rd_en",    32'(rd_en_seen), 32'd0);
    chk_eq("t3_bp_unstable", 32'(unstable),   32'd0);
    ifa.out_ready = 1'b1;
    step();
    chk_eq("t3_hs_rd_count", 32'(ifa.rd_count),  32'd1);
    chk_eq("t3_hs_checksum", 32'(ifa.checksum),  32'h11);
    chk_eq("t3_hs_valid",    32'(ifa.out_valid), 32'd0);
    wait_a_done("t3_done_seen", 40);
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    chk_eq("t3_start_at_done_busy", 32'(ifa.busy), 32'd0);
    step();
    chk_eq("t3_idle_busy",     32'(ifa.busy),     32'd0);
    chk_eq("t3_idle_rd_count", 32'(ifa.rd_count), 32'd4);
    chk_eq("t3_idle_checksum", 32'(ifa.checksum), 32'h44);
    chk_eq("t3_pulses",        32'(a_pulses),     32'd4);

    // Reset while holding the third word, then a fresh full burst
    a_clr     = 1'b1;
    ifa.start = 1'b1;
    step();
    a_clr     = 1'b0;
    ifa.start = 1'b0;
    for (int i = 0; i < 30 && ifa.rd_count != 10'd2; i++) step();
    chk_eq("t4_reach_two", 32'(ifa.rd_count), 32'd2);
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 10 && !ifa.out_valid; i++) step();
    chk_eq("t4_holding", 32'(ifa.out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    chk_eq("t4_rst_rd_en",     32'(ifa.rd_en),     32'd0);
    chk_eq("t4_rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk_eq("t4_rst_out_data",  32'(ifa.out_data),  32'd0);
    chk_eq("t4_rst_busy",      32'(ifa.busy),      32'd0);
    chk_eq("t4_rst_rd_count",  32'(ifa.rd_count),  32'd0);
    chk_eq("t4_rst_checksum",  32'(ifa.checksum),  32'd0);
    rst_n         = 1'b1;
    ifa.out_ready = 1'b1;
    a_clr         = 1'b1;
    ifa.start     = 1'b1;
    step();
    a_clr     = 1'b0;
    ifa.start = 1'b0;
    wait_a_done("t4_done_seen", 40);
    step();
    chk_eq("t4_rd_count", 32'(ifa.rd_count), 32'd4);
    chk_eq("t4_checksum", 32'(ifa.checksum), 32'h44);
    chk_eq("t4_pulses",   32'(a_pulses),     32'd4);

    // Pop must drop in the very cycle reset is asserted
    a_clr     = 1'b1;
    ifa.start = 1'b1;
    step();
    a_clr     = 1'b0;
    ifa.start = 1'b0;
    chk_eq("t5_read_rd_en", 32'(ifa.rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("t5_rst_rd_en", 32'(ifa.rd_en), 32'd0);
    step();
    rst_n = 1'b1;
    chk_eq("t5_rst_busy", 32'(ifa.busy), 32'd0);

    // Default-length burst with no idle cycles on instance B
    b_clr     = 1'b1;
    ifb.start = 1'b1;
    step();
    b_clr     = 1'b0;
    ifb.start = 1'b0;
    for (int i = 0; i < 1200 && !ifb.done; i++) step();
    chk_eq("t6_done_seen", 32'(ifb.done), 32'd1);
    step();
    chk_eq("t6_pulses",     32'(b_pulses),               32'd333);
    chk_eq("t6_pulse_span", 32'(b_last - b_first),       32'd996);
    chk_eq("t6_done_delay", 32'(b_done_cyc - b_start_cyc), 32'd1000);
    chk_eq("t6_rd_count",   32'(ifb.rd_count),           32'd333);
    // Bytes 1..255 XOR to 0, then 0..77 XOR to 1
    chk_eq("t6_checksum",   32'(ifb.checksum),           32'h01);
    chk_eq("t6_busy_low",   32'(ifb.busy),               32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
